// File: rtl/bandit_environment_if.sv
// rtl/bandit_environment_if.sv - action, reward and config handshake bundle for bandit_environment
interface bandit_environment_if;
  logic       action_valid;
  logic [7:0] action_data;
  logic       action_ready;
  logic       reward_valid;
  logic [7:0] reward_data;
  logic       reward_ready;
  logic       config_valid;
  logic [7:0] config_addr;
  logic [7:0] config_prob;
  logic [7:0] config_payoff;

  modport master (
    output action_valid, action_data, reward_ready,
    output config_valid, config_addr, config_prob, config_payoff,
    input  action_ready, reward_valid, reward_data
  );

  modport slave (
    input  action_valid, action_data, reward_ready,
    input  config_valid, config_addr, config_prob, config_payoff,
    output action_ready, reward_valid, reward_data
  );
endinterface

// File: rtl/bandit_environment.sv
// rtl/bandit_environment.sv - multi-armed bandit environment: per-arm payout table, LFSR draw, delayed reward
module bandit_environment #(
  parameter int unsigned DELAY = 10,
  parameter logic [15:0] SEED  = 16'hACE1
) (
  input  logic                 clock,
  input  logic                 reset,
  bandit_environment_if.slave  bus,
  output logic [15:0]          pulls
);
  typedef enum logic [1:0] {IDLE, WAIT, REWARD} state_t;

  localparam logic [7:0] DELAY_CNT = 8'(DELAY);

  state_t      state;
  logic [7:0]  delay_cnt;
  logic [15:0] lfsr;
  logic        lfsr_fb;
  logic [7:0]  prob_tbl   [256];
  logic [7:0]  payoff_tbl [256];
  logic [7:0]  lat_prob;
  logic [7:0]  lat_payoff;
  logic [7:0]  lat_rnd;
  logic        reward_valid_q;
  logic [7:0]  reward_data_q;
  logic        accept;
  logic        reward_done;

  function automatic logic [7:0] payout(input logic [7:0] prob, input logic [7:0] payoff,
                                        input logic [7:0] rnd);
    return ((prob == 8'hFF) || (rnd < prob)) ? payoff : 8'h00;
  endfunction

  // Ready is gated by reset so it is low during reset and high right after release.
  assign bus.action_ready = (state == IDLE) && !reset;
  assign bus.reward_valid = reward_valid_q;
  assign bus.reward_data  = reward_data_q;

  assign accept      = bus.action_valid && bus.action_ready;
  assign reward_done = reward_valid_q && bus.reward_ready;
  assign lfsr_fb     = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  // Table is not reset; a write in the accepting cycle lands after the old entry is read.
  always_ff @(posedge clock) begin
    if (bus.config_valid) begin
      prob_tbl[bus.config_addr]   <= bus.config_prob;
      payoff_tbl[bus.config_addr] <= bus.config_payoff;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      delay_cnt      <= 8'd0;
      lfsr           <= SEED;
      pulls          <= 16'd0;
      reward_valid_q <= 1'b0;
      reward_data_q  <= 8'h00;
      lat_prob       <= 8'h00;
      lat_payoff     <= 8'h00;
      lat_rnd        <= 8'h00;
    end else begin
      lfsr <= {lfsr[14:0], lfsr_fb};
      case (state)
        IDLE: begin
          if (accept) begin
            lat_prob   <= prob_tbl[bus.action_data];
            lat_payoff <= payoff_tbl[bus.action_data];
            lat_rnd    <= lfsr[7:0];
            if (pulls != 16'hFFFF) begin
              pulls <= pulls + 16'd1;
            end
            if (DELAY_CNT == 8'd0) begin
              state          <= REWARD;
              reward_valid_q <= 1'b1;
              reward_data_q  <= payout(prob_tbl[bus.action_data], payoff_tbl[bus.action_data],
                                       lfsr[7:0]);
            end else begin
              state     <= WAIT;
              delay_cnt <= DELAY_CNT;
            end
          end
        end
        WAIT: begin
          delay_cnt <= delay_cnt - 8'd1;
          if (delay_cnt == 8'd1) begin
            state          <= REWARD;
            reward_valid_q <= 1'b1;
            reward_data_q  <= payout(lat_prob, lat_payoff, lat_rnd);
          end
        end
        REWARD: begin
          if (reward_done) begin
            state          <= IDLE;
            reward_valid_q <= 1'b0;
          end
        end
        default: begin
          state          <= IDLE;
          reward_valid_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bandit_environment.sv
// tb/tb_bandit_environment.sv - randomized bench for bandit_environment against a table and LFSR-sequence model
module tb_bandit_environment;
  localparam int          DLY_A = 10;
  localparam int          DLY_B = 0;
  localparam logic [15:0] SEED  = 16'hACE1;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic [1:0] rst;
  logic [1:0] av;
  logic [1:0] rr;
  logic [1:0] cv;
  logic [7:0] ad [2];
  logic [7:0] ca [2];
  logic [7:0] cp [2];
  logic [7:0] cy [2];
  wire  [1:0] ar;
  wire  [1:0] rv;
  wire  [7:0] rd [2];
  wire [15:0] pl [2];

  bandit_environment_if if_a ();
  bandit_environment_if if_b ();

  bandit_environment #(.DELAY(DLY_A), .SEED(SEED)) dut_a (
    .clock(clock), .reset(rst[0]), .bus(if_a), .pulls(pl[0]));
  bandit_environment #(.DELAY(DLY_B), .SEED(SEED)) dut_b (
    .clock(clock), .reset(rst[1]), .bus(if_b), .pulls(pl[1]));

  assign if_a.action_valid  = av[0];
  assign if_a.action_data   = ad[0];
  assign if_a.reward_ready  = rr[0];
  assign if_a.config_valid  = cv[0];
  assign if_a.config_addr   = ca[0];
  assign if_a.config_prob   = cp[0];
  assign if_a.config_payoff = cy[0];
  assign ar[0] = if_a.action_ready;
  assign rv[0] = if_a.reward_valid;
  assign rd[0] = if_a.reward_data;

  assign if_b.action_valid  = av[1];
  assign if_b.action_data   = ad[1];
  assign if_b.reward_ready  = rr[1];
  assign if_b.config_valid  = cv[1];
  assign if_b.config_addr   = ca[1];
  assign if_b.config_prob   = cp[1];
  assign if_b.config_payoff = cy[1];
  assign ar[1] = if_b.action_ready;
  assign rv[1] = if_b.reward_valid;
  assign rd[1] = if_b.reward_data;

  // Model: full LFSR sequence indexed by clock edges since reset release, plus per-arm tables.
  logic [15:0] lfsr_seq [65535];
  int          cyc [2];
  logic [7:0]  m_prob [2][256];
  logic [7:0]  m_pay  [2][256];
  int          m_pulls [2];
  int          dly [2];
  int          vectors;
  int          miscompares;
  logic [7:0]  run_rew [2][4096];

  always @(posedge clock) begin
    for (int w = 0; w < 2; w++) begin
      if (!rst[w]) cyc[w] = cyc[w] + 1;
    end
  end

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cfg(input int w, input logic [7:0] a, input logic [7:0] p, input logic [7:0] y);
    cv[w] = 1'b1; ca[w] = a; cp[w] = p; cy[w] = y;
    m_prob[w][a] = p; m_pay[w][a] = y;
    @(negedge clock);
    cv[w] = 1'b0;
  endtask

  task automatic do_reset(input int w);
    rst[w] = 1'b1;
    #1;
    check("rst_valid", 32'(rv[w]), 32'd0);
    check("rst_ready", 32'(ar[w]), 32'd0);
    check("rst_data", 32'(rd[w]), 32'd0);
    check("rst_pulls", 32'(pl[w]), 32'd0);
    @(negedge clock);
    rst[w] = 1'b0; cyc[w] = 0; m_pulls[w] = 0;
    #1;
    check("ready_after_rst", 32'(ar[w]), 32'd1);
  endtask

  task automatic pull(input int w, input logic [7:0] arm, input int bp, input bit cfg_same,
                      output logic [7:0] got);
    int n;
    logic [7:0] rnd;
    logic [7:0] exp_r;
    n = 0;
    while (ar[w] !== 1'b1 && n < 20) begin @(negedge clock); n++; end
    check("ready_idle", 32'(ar[w]), 32'd1);
    rnd   = lfsr_seq[cyc[w] % 65535][7:0];
    exp_r = ((m_prob[w][arm] == 8'hFF) || (rnd < m_prob[w][arm])) ? m_pay[w][arm] : 8'h00;
    av[w] = 1'b1; ad[w] = arm;
    if (cfg_same) begin
      cv[w] = 1'b1; ca[w] = arm; cp[w] = 8'($urandom); cy[w] = 8'($urandom);
      m_prob[w][arm] = cp[w]; m_pay[w][arm] = cy[w];
    end
    @(negedge clock);
    cv[w] = 1'b0;
    if (m_pulls[w] < 65535) m_pulls[w]++;
    check("busy_after_accept", 32'(ar[w]), 32'd0);
    n = 1;
    while (rv[w] !== 1'b1 && n < 300) begin
      av[w] = 1'($urandom); ad[w] = 8'($urandom);
      @(negedge clock);
      n++;
    end
    check("latency", 32'(n), 32'(dly[w] + 1));
    check("reward_data", 32'(rd[w]), 32'(exp_r));
    check("pulls", 32'(pl[w]), 32'(m_pulls[w]));
    got = rd[w];
    for (int i = 0; i < bp; i++) begin
      av[w] = 1'($urandom);
      @(negedge clock);
      check("hold_valid", 32'(rv[w]), 32'd1);
      check("hold_data", 32'(rd[w]), 32'(exp_r));
      check("hold_ready", 32'(ar[w]), 32'd0);
    end
    rr[w] = 1'b1; av[w] = 1'($urandom);
    @(negedge clock);
    rr[w] = 1'b0; av[w] = 1'b0;
    check("ready_after_done", 32'(ar[w]), 32'd1);
    check("valid_after_done", 32'(rv[w]), 32'd0);
    check("pulls_unchanged", 32'(pl[w]), 32'(m_pulls[w]));
  endtask

  initial begin
    logic [7:0] got;
    int n;
    int cnt;
    vectors = 0; miscompares = 0;
    rst = 2'b11; av = 2'b00; rr = 2'b00; cv = 2'b00;
    for (int w = 0; w < 2; w++) begin
      ad[w] = 8'h00; ca[w] = 8'h00; cp[w] = 8'h00; cy[w] = 8'h00;
      cyc[w] = 0; m_pulls[w] = 0;
    end
    dly[0] = DLY_A; dly[1] = DLY_B;
    lfsr_seq[0] = SEED;
    for (int i = 1; i < 65535; i++) lfsr_seq[i] = lfsr_step(lfsr_seq[i-1]);

    @(negedge clock);
    do_reset(0);
    do_reset(1);

    // Fill every arm of both tables so any random pull has a known entry.
    for (int i = 0; i < 256; i++) begin
      for (int w = 0; w < 2; w++) begin
        cv[w] = 1'b1; ca[w] = 8'(i); cp[w] = 8'($urandom); cy[w] = 8'($urandom);
        m_prob[w][i] = cp[w]; m_pay[w][i] = cy[w];
      end
      @(negedge clock);
    end
    cv = 2'b00;

    // Certain payout with DELAY 10, then 20 cycles of backpressure.
    cfg(0, 8'd64, 8'hFF, 8'h03);
    pull(0, 8'd64, 0, 1'b0, got);
    check("certain_pay", 32'(got), 32'h03);
    check("certain_pulls", 32'(pl[0]), 32'd1);
    pull(0, 8'd64, 20, 1'b0, got);
    check("bp_pay", 32'(got), 32'h03);

    // Probability zero never pays.
    cfg(0, 8'd5, 8'h00, 8'hF9);
    do_reset(0);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      pull(0, 8'd5, 0, 1'b0, got);
      if (got != 8'h00) cnt++;
    end
    check("never_pays", 32'(cnt), 32'd0);
    check("never_pulls", 32'(pl[0]), 32'd100);

    // Reset three cycles into WAIT abandons the reward.
    av[0] = 1'b1; ad[0] = 8'd64;
    @(negedge clock);
    av[0] = 1'b0;
    repeat (3) @(negedge clock);
    rst[0] = 1'b1;
    #1;
    check("wait_rst_valid", 32'(rv[0]), 32'd0);
    @(negedge clock);
    rst[0] = 1'b0; cyc[0] = 0; m_pulls[0] = 0;
    cnt = 0;
    repeat (15) begin @(negedge clock); if (rv[0] === 1'b1) cnt++; end
    check("abandoned_reward", 32'(cnt), 32'd0);
    check("abandoned_pulls", 32'(pl[0]), 32'd0);

    // Reset while the reward is presented drops reward_valid at once.
    av[0] = 1'b1; ad[0] = 8'd64;
    @(negedge clock);
    av[0] = 1'b0;
    n = 0;
    while (rv[0] !== 1'b1 && n < 30) begin @(negedge clock); n++; end
    check("reached_reward", 32'(rv[0]), 32'd1);
    rst[0] = 1'b1;
    #1;
    check("reward_rst_valid", 32'(rv[0]), 32'd0);
    @(negedge clock);
    rst[0] = 1'b0; cyc[0] = 0; m_pulls[0] = 0;
    pull(0, 8'd64, 0, 1'b0, got);
    check("after_rst_pulls", 32'(pl[0]), 32'd1);

    // DELAY 0 with a same-cycle write to the pulled arm.
    cfg(1, 8'd64, 8'hFF, 8'h11);
    pull(1, 8'd64, 0, 1'b1, got);
    check("old_entry_used", 32'(got), 32'h11);

    // Statistics: two identical runs of 4096 pulls of arm 1 from reset.
    cfg(1, 8'd1, 8'h80, 8'h01);
    for (int r = 0; r < 2; r++) begin
      do_reset(1);
      cnt = 0;
      for (int i = 0; i < 4096; i++) begin
        pull(1, 8'd1, 0, 1'b0, got);
        run_rew[r][i] = got;
        if (got != 8'h00) cnt++;
      end
      check("hit_range", 32'((cnt >= 1920) && (cnt <= 2176)), 32'd1);
    end
    cnt = 0;
    for (int i = 0; i < 4096; i++) if (run_rew[0][i] !== run_rew[1][i]) cnt++;
    check("repeat_sequence", 32'(cnt), 32'd0);

    // Random mix of arms, reconfigs and backpressure on both instances.
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 3) == 0) cfg(0, 8'($urandom), 8'($urandom), 8'($urandom));
      pull(0, 8'($urandom), int'($urandom_range(0, 3)), 1'($urandom), got);
    end
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) cfg(1, 8'($urandom), 8'($urandom), 8'($urandom));
      pull(1, 8'($urandom), int'($urandom_range(0, 3)), 1'($urandom), got);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/bandit_environment.md
BANDIT_ENVIRONMENT -- requirements
Module: bandit_environment

Interface
REQ-001 Parameter DELAY, default 10: cycles inserted between action accept and reward presentation (0..255).
REQ-002 Parameter SEED, default 16'hACE1: LFSR reset value; SHALL be nonzero.
REQ-003 clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 action_valid  input  1  agent presents an action.
REQ-006 action_data  input  8  arm index.
REQ-007 action_ready  output  1  block accepts an action.
REQ-008 reward_valid  output  1  reward presented to agent.
REQ-009 reward_data  output  8  signed two's-complement reward.
REQ-010 reward_ready  input  1  agent accepts the reward.
REQ-011 config_valid  input  1  table write strobe, accepted every cycle.
REQ-012 config_addr  input  8  arm index to write.
REQ-013 config_prob  input  8  unsigned payout probability, in units of 1/256.
REQ-014 config_payoff  input  8  signed payout magnitude.
REQ-015 pulls  output  16  count of accepted actions.

Function
REQ-016 The block SHALL hold a 256-entry table of {prob, payoff}; table contents SHALL NOT be reset.
REQ-017 config_valid high at a rising edge SHALL write both table fields at config_addr.
REQ-018 A 16-bit Fibonacci LFSR (taps 16,14,13,11) SHALL advance every cycle out of reset.
REQ-019 FSM states: IDLE, WAIT, REWARD.
REQ-020 action_ready SHALL equal 1 only in IDLE; reward_valid SHALL equal 1 only in REWARD.
REQ-021 An action is accepted at a rising edge with action_valid and action_ready both high.
REQ-022 On accept, the block SHALL latch the table entry and LFSR[7:0].
REQ-023 On accept, the FSM SHALL go to WAIT with delay counter = DELAY, or straight to REWARD if DELAY = 0.
REQ-024 WAIT SHALL decrement the counter each cycle and enter REWARD when the counter reaches 0.
REQ-025 Latency: reward_valid SHALL rise exactly DELAY+1 cycles after the accepting edge.
REQ-026 reward_data SHALL be the latched payoff when latched prob = 8'hFF or latched LFSR[7:0] < latched prob, else 8'h00.
REQ-027 prob = 0 SHALL always yield reward 0.
REQ-028 reward_data SHALL remain stable while reward_valid is high and reward_ready is low.
REQ-029 When reward_valid and reward_ready are both high at a rising edge, the FSM SHALL return to IDLE.
REQ-030 action_ready SHALL be 1 on the cycle after reward completion; back-to-back pulls have no bubble beyond this.
REQ-031 A config write to the same arm in the accepting cycle SHALL NOT affect that pull, which uses the old entry.
REQ-032 pulls SHALL increment on each accept and saturate at 16'hFFFF.
REQ-033 action_data and action_valid SHALL be ignored outside IDLE.

Reset
REQ-034 Reset SHALL force, asynchronously: state IDLE, delay counter 0, LFSR = SEED, pulls 0, reward_data 0, reward_valid 0.
REQ-035 action_ready SHALL be 0 while reset is asserted and 1 on the first cycle after deassertion.
REQ-036 Reset asserted in WAIT or REWARD SHALL abandon the pending reward; reward_valid SHALL drop immediately.
REQ-037 pulls SHALL NOT count the abandoned pull again after reset.

Verification
REQ-038 Certain payout: arm 64 = {FF, +3}, DELAY = 10, pull arm 64 -> reward_valid rises 11 cycles after accept with data 8'h03; pulls = 1.
REQ-039 Never pays: arm 5 = {00, -7}, 100 pulls of arm 5 -> every reward = 0; pulls = 100.
REQ-040 Backpressure: hold reward_ready low for 20 cycles -> reward_valid and reward_data stay constant; action_ready stays 0 throughout.
REQ-041 Statistics: arm 1 = {80, +1}, 4096 pulls from reset with SEED default -> hit count within 2048 +/- 128, and a repeated run gives an identical sequence.
REQ-042 Reset mid-operation: assert reset 3 cycles into WAIT -> reward_valid stays 0; next pull succeeds with pulls = 1.
REQ-043 Simultaneous events: DELAY = 0, and a config write to arm 64 in the accepting cycle -> the reward uses the old entry and arrives 1 cycle after accept.
